spi_arb: RTL and testbench
==========================

SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 SHALL have parameter A_WIDTH, default 16, meaning the SPI register address width.
REQ-002 SHALL have parameter D_WIDTH, default 8, meaning the SPI data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUSY cycles allowed before a transaction is aborted.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports req0/req1, input, 1 bit each: the requester holds its request high until it sees gnt.
REQ-007 SHALL have ports rw0/rw1, input, 1 bit each: 0 = write, 1 = read.
REQ-008 SHALL have ports addr0/addr1, input, A_WIDTH each: the transaction address.
REQ-009 SHALL have ports wdata0/wdata1, input, D_WIDTH each: the write data.
REQ-010 SHALL have ports gnt0/gnt1, output, 1 bit each: a one-cycle pulse meaning the command has been accepted.
REQ-011 SHALL have ports done0/done1, output, 1 bit each: a one-cycle completion pulse.
REQ-012 SHALL have ports rdata0/rdata1, output, D_WIDTH each: the read result, held until the next read by the same requester.
REQ-013 SHALL have port err, output, 1 bit: valid together with the done pulse; 1 = the transaction timed out.
REQ-014 SHALL have ports m_start, output, 1 bit; m_r_w, output, 2 bits; m_w_addr, output, A_WIDTH; m_w_data, output, D_WIDTH; m_r_addr, output, A_WIDTH. These drive the spi_t parallel side.
REQ-015 SHALL have ports m_r_data, input, D_WIDTH, and m_done, input, 1 bit: a one-cycle pulse from the SPI master at the end of a frame.

Function
REQ-016 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-017 In IDLE with any reqN high, SHALL select a winner by round-robin, latch its rw/addr/wdata, pulse its gnt for 1 cycle, and go to BUSY on the same edge.
REQ-018 Round-robin: the pointer SHALL initially favour requester 0, and SHALL point to the non-served requester after each completion or abort.
REQ-019 With both requests high, SHALL grant the pointed-to requester; with one request high, SHALL grant that requester regardless of the pointer.
REQ-020 In BUSY, SHALL hold m_start=1 and SHALL keep the m_* command outputs constant until BUSY is left.
REQ-021 Write command drive: m_r_w=2'b00, m_w_addr=addr, m_w_data=wdata, m_r_addr held at 0.
REQ-022 Read command drive: m_r_w=2'b11, m_r_addr=addr, m_w_addr and m_w_data held at 0.
REQ-023 On m_done in BUSY, SHALL drop m_start on the next edge, capture m_r_data into the owner's rdata if the transaction is a read, and go to DONE.
REQ-024 DONE SHALL last exactly 1 cycle, pulse the owner's done with err=0, then return to IDLE; grant-to-grant spacing is therefore at least 3 cycles.
REQ-025 A BUSY cycle counter SHALL start at 0 on entry and saturate at TIMEOUT.
REQ-026 If the BUSY counter reaches TIMEOUT with no m_done, SHALL abort: drop m_start, go to DONE, pulse done with err=1, leave rdata unchanged, and advance the pointer.
REQ-027 SHALL ignore m_done outside BUSY.
REQ-028 If m_done arrives on the TIMEOUT cycle, SHALL complete normally with err=0.
REQ-029 Requests arriving in BUSY or DONE SHALL wait, with no loss and no gnt, and SHALL NOT alter the latched command.
REQ-030 Requester inputs SHALL be sampled only in IDLE, so a requester dropping req before gnt is not served.
REQ-031 gnt0/gnt1 SHALL be mutually exclusive, and done0/done1 SHALL be mutually exclusive.

Reset
REQ-032 While rst=0: state=IDLE, pointer=0, counter=0, and all outputs 0 (gnt*, done*, err, rdata*, m_start, m_r_w, m_w_addr, m_w_data, m_r_addr).
REQ-033 Reset mid-transaction SHALL abort with no done pulse; m_start SHALL fall asynchronously.
REQ-034 The first grant after reset release SHALL occur no earlier than the first rising edge with rst=1.

Structure
REQ-035 Package spi_pkg SHALL hold A_WIDTH/D_WIDTH defaults, the r_w encodings RW_WRITE=2'b00 and RW_READ=2'b11, and the FSM state enumeration.
REQ-036 The 2-way round-robin selection SHALL be a separate sub-module, rr_arb2: inputs req[1:0], ptr, advance; output one-hot grant.
REQ-037 The target size is 120-400 lines of RTL, with no other sub-modules.

Verification
REQ-038 Single write: req0=1, rw0=0, addr0=16'hfffe, wdata0=8'hfe -> gnt0 pulse; m_r_w=00, m_w_addr=fffe, m_w_data=fe with m_start=1 until m_done; then done0=1, err=0.
REQ-039 Read: req1=1, rw1=1, addr1=16'hfffd; model returns m_r_data=8'hfd -> m_r_addr=fffd, m_r_w=11; after done1, rdata1=8'hfd and rdata0 unchanged.
REQ-040 Contention: req0 and req1 held high for 4 transactions -> grants in order 0,1,0,1; never two gnt in one cycle.
REQ-041 Timeout: TIMEOUT=20, model never pulses m_done -> m_start falls after 20 BUSY cycles; done0=1, err=1; rdata0 unchanged.
REQ-042 Reset mid-BUSY: rst=0 on cycle 10 of a transaction -> all outputs 0 immediately, no done; after release, a new req0 is granted and completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg -- shared definitions for the two-requester SPI command arbiter.
//   DEF_A_WIDTH / DEF_D_WIDTH : default address / data widths
//   RW_WRITE / RW_READ        : r_w encodings expected by the SPI master
//   state_t                   : arbiter FSM states
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int DEF_A_WIDTH = 16;
  localparam int DEF_D_WIDTH = 8;

  localparam logic [1:0] RW_WRITE = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/spi_arb_if.sv
// ---------------------------------------------------------------------------
// spi_arb_if -- all handshake/bus signals around the arbiter.
//   Requester side : req0/1, rw0/1, addr0/1, wdata0/1 (to arbiter)
//                    gnt0/1, done0/1, rdata0/1, err   (from arbiter)
//   SPI side       : m_start, m_r_w, m_w_addr, m_w_data, m_r_addr (to master)
//                    m_r_data, m_done                           (from master)
//   modport slave  : the arbiter's view
//   modport master : the environment's view (requesters + SPI master)
// ---------------------------------------------------------------------------
interface spi_arb_if
  import spi_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int D_WIDTH = DEF_D_WIDTH
) ();

  logic               req0,   req1;
  logic               rw0,    rw1;
  logic [A_WIDTH-1:0] addr0,  addr1;
  logic [D_WIDTH-1:0] wdata0, wdata1;
  logic               gnt0,   gnt1;
  logic               done0,  done1;
  logic [D_WIDTH-1:0] rdata0, rdata1;
  logic               err;

  logic               m_start;
  logic [1:0]         m_r_w;
  logic [A_WIDTH-1:0] m_w_addr;
  logic [D_WIDTH-1:0] m_w_data;
  logic [A_WIDTH-1:0] m_r_addr;
  logic [D_WIDTH-1:0] m_r_data;
  logic               m_done;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    input  m_r_data, m_done,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, err,
    output m_start, m_r_w, m_w_addr, m_w_data, m_r_addr
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    output m_r_data, m_done,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, err,
    input  m_start, m_r_w, m_w_addr, m_w_data, m_r_addr
  );

endinterface

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 -- combinational 2-way round-robin selector.
//   req[1:0] : pending requests
//   ptr      : favoured requester when both request (0 or 1)
//   advance  : selection enable; grant is all-zero while low
//   grant    : one-hot winner
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       advance,
  output logic [1:0] grant
);

  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (advance) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/spi_arb.sv
// ---------------------------------------------------------------------------
// spi_arb -- arbitrates two requesters onto one SPI master command port.
//   clk : single clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : spi_arb_if.slave (requester handshakes + SPI master parallel side)
// One command is in flight at a time: IDLE picks a winner and latches its
// command, BUSY drives the SPI master until m_done or timeout, DONE reports
// completion for one cycle.
// ---------------------------------------------------------------------------
module spi_arb
  import spi_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int TIMEOUT = 255
) (
  input logic      clk,
  input logic      rst,
  spi_arb_if.slave bus
);

  localparam int            CW     = $clog2(TIMEOUT + 1);
  // Counter value during the last permitted BUSY cycle; it is 0 on the first.
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);

  state_t             r_state, w_state_nxt;
  logic               r_ptr;      // requester favoured on contention
  logic               r_owner;    // requester owning the current command
  logic               r_is_read;
  logic [CW-1:0]      r_cnt;      // BUSY cycles elapsed, saturating

  logic [1:0]         w_grant;
  logic               w_accept, w_finish, w_abort;
  logic               w_sel_rw;
  logic [A_WIDTH-1:0] w_sel_addr;
  logic [D_WIDTH-1:0] w_sel_wdata;

  // Requests are only looked at in IDLE, so late or dropped requests in
  // BUSY/DONE can neither be granted nor disturb the latched command.
  rr_arb2 u_rr (
    .req     ({bus.req1, bus.req0}),
    .ptr     (r_ptr),
    .advance (r_state == IDLE),
    .grant   (w_grant)
  );

  assign w_sel_rw    = w_grant[1] ? bus.rw1    : bus.rw0;
  assign w_sel_addr  = w_grant[1] ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_grant[1] ? bus.wdata1 : bus.wdata0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // m_done wins over a timeout landing on the same cycle.
        if (bus.m_done) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end else if (r_cnt == C_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: rdata0/rdata1 are reset along with the rest of the outputs; they
  // are two registers, not a memory array, so the reset costs nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr        <= 1'b0;
      r_owner      <= 1'b0;
      r_is_read    <= 1'b0;
      r_cnt        <= '0;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.done0    <= 1'b0;
      bus.done1    <= 1'b0;
      bus.err      <= 1'b0;
      bus.rdata0   <= '0;
      bus.rdata1   <= '0;
      bus.m_start  <= 1'b0;
      bus.m_r_w    <= RW_WRITE;
      bus.m_w_addr <= '0;
      bus.m_w_data <= '0;
      bus.m_r_addr <= '0;
    end else begin
      // Handshake outputs are single-cycle pulses.
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.err   <= 1'b0;

      if (w_accept) begin
        bus.gnt0    <= w_grant[0];
        bus.gnt1    <= w_grant[1];
        r_owner     <= w_grant[1];
        r_is_read   <= w_sel_rw;
        r_cnt       <= '0;
        bus.m_start <= 1'b1;
        // Unused command fields are driven to zero for the whole transaction.
        if (w_sel_rw) begin
          bus.m_r_w    <= RW_READ;
          bus.m_r_addr <= w_sel_addr;
          bus.m_w_addr <= '0;
          bus.m_w_data <= '0;
        end else begin
          bus.m_r_w    <= RW_WRITE;
          bus.m_r_addr <= '0;
          bus.m_w_addr <= w_sel_addr;
          bus.m_w_data <= w_sel_wdata;
        end
      end else if (r_state == BUSY && r_cnt != C_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_finish || w_abort) begin
        bus.m_start <= 1'b0;
        bus.done0   <= ~r_owner;
        bus.done1   <= r_owner;
        bus.err     <= w_abort;
        r_ptr       <= ~r_owner;
        if (w_finish && r_is_read) begin
          if (r_owner) bus.rdata1 <= bus.m_r_data;
          else         bus.rdata0 <= bus.m_r_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// ---------------------------------------------------------------------------
// tb_spi_arb -- directed self-checking bench for spi_arb (TIMEOUT = 20).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_spi_arb;
  import spi_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  int   who;
  int   bad;

  spi_arb_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

  spi_arb #(.A_WIDTH(AW), .D_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Returns 0/1 for the granted requester, 2 if both grants fire together,
  // -1 if no grant appears within the budget.
  task automatic wait_gnt(output int w);
    w = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.gnt0 && bus.gnt1) begin w = 2; break; end
      if (bus.gnt0)             begin w = 0; break; end
      if (bus.gnt1)             begin w = 1; break; end
    end
  endtask

  // Called on the negedge where gnt was seen: one BUSY cycle, then m_done.
  task automatic finish_txn(input int owner, input logic [7:0] rd);
    @(negedge clk);
    bus.m_r_data = rd;
    bus.m_done   = 1'b1;
    @(negedge clk);
    bus.m_done   = 1'b0;
    check("done_owner", {bus.done1, bus.done0}, (owner == 1) ? 2'b10 : 2'b01);
    check("done_err", bus.err, 1'b0);
    check("done_mstart", bus.m_start, 1'b0);
    @(negedge clk);
    check("done_pulse", {bus.done1, bus.done0}, 2'b00);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.req0   = 1'b0;  bus.req1   = 1'b0;
    bus.rw0    = 1'b0;  bus.rw1    = 1'b0;
    bus.addr0  = '0;    bus.addr1  = '0;
    bus.wdata0 = '0;    bus.wdata1 = '0;
    bus.m_r_data = '0;  bus.m_done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt",    {bus.gnt1, bus.gnt0}, 2'b00);
    check("rst_done",   {bus.done1, bus.done0, bus.err}, 3'b000);
    check("rst_mstart", bus.m_start, 1'b0);
    check("rst_mrw",    bus.m_r_w, 2'b00);
    check("rst_cmd",    {bus.m_w_addr, bus.m_w_data}, 24'h0);
    check("rst_mraddr", bus.m_r_addr, 16'h0);
    check("rst_rdata",  {bus.rdata1, bus.rdata0}, 16'h0);

    // Single write; request raised while still in reset
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 16'hfffe; bus.wdata0 = 8'hfe;
    @(negedge clk);
    check("rst_hold_gnt", bus.gnt0, 1'b0);
    rst_n = 1'b1;
    #1 check("rel_no_gnt", bus.gnt0, 1'b0);
    wait_gnt(who);
    check("wr_gnt", who, 0);
    check("wr_mstart", bus.m_start, 1'b1);
    check("wr_mrw", bus.m_r_w, RW_WRITE);
    check("wr_maddr", bus.m_w_addr, 16'hfffe);
    check("wr_mdata", bus.m_w_data, 8'hfe);
    check("wr_mraddr", bus.m_r_addr, 16'h0);
    bus.req0 = 1'b0;
    @(negedge clk);
    check("wr_gnt_pulse", bus.gnt0, 1'b0);
    check("wr_mstart_hold", bus.m_start, 1'b1);
    finish_txn(0, 8'h77);
    check("wr_rdata0", bus.rdata0, 8'h00);

    // m_done while IDLE does nothing
    bus.m_done = 1'b1;
    @(negedge clk);
    bus.m_done = 1'b0;
    check("idle_mdone", {bus.done1, bus.done0, bus.m_start}, 3'b000);

    // Read by requester 1; requester 0 queues during BUSY
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 16'hfffd;
    wait_gnt(who);
    check("rd_gnt", who, 1);
    check("rd_mrw", bus.m_r_w, RW_READ);
    check("rd_mraddr", bus.m_r_addr, 16'hfffd);
    check("rd_wzero", {bus.m_w_addr, bus.m_w_data}, 24'h0);
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 16'h1234; bus.wdata0 = 8'h55;
    @(negedge clk);
    check("busy_no_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
    check("busy_cmd_hold", {bus.m_r_w, bus.m_r_addr}, {RW_READ, 16'hfffd});
    finish_txn(1, 8'hfd);
    check("rd_rdata1", bus.rdata1, 8'hfd);
    check("rd_rdata0", bus.rdata0, 8'h00);

    // Contention: both held high, expect 0,1,0,1
    bus.req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_gnt(who);
      check("cont_order", who, t % 2);
      if (t == 0) check("cont_queued_cmd", {bus.m_w_addr, bus.m_w_data}, {16'h1234, 8'h55});
      if (t == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      finish_txn(t % 2, 8'(8'h10 + t));
    end
    check("cont_rdata1", bus.rdata1, 8'h13);
    check("cont_rdata0", bus.rdata0, 8'h00);

    // Timeout: no m_done for requester 0 read
    bus.req0 = 1'b1; bus.rw0 = 1'b1; bus.addr0 = 16'h0abc; bus.m_r_data = 8'hee;
    wait_gnt(who);
    check("to_gnt", who, 0);
    bus.req0 = 1'b0;
    bad = 0;
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      if (!bus.m_start) bad++;
    end
    check("to_mstart_held", bad, 0);
    @(negedge clk);
    check("to_mstart_fall", bus.m_start, 1'b0);
    check("to_done", {bus.done1, bus.done0}, 2'b01);
    check("to_err", bus.err, 1'b1);
    check("to_rdata0", bus.rdata0, 8'h00);
    @(negedge clk);
    check("to_pulse", {bus.done0, bus.err}, 2'b00);

    // m_done on the last permitted BUSY cycle completes normally
    bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 16'h0bcd;
    wait_gnt(who);
    check("edge_gnt", who, 1);
    bus.req1 = 1'b0;
    repeat (TO - 1) @(negedge clk);
    bus.m_r_data = 8'hc3;
    bus.m_done   = 1'b1;
    @(negedge clk);
    bus.m_done   = 1'b0;
    check("edge_done", {bus.done1, bus.done0}, 2'b10);
    check("edge_err", bus.err, 1'b0);
    check("edge_rdata1", bus.rdata1, 8'hc3);
    @(negedge clk);

    // Reset on cycle 10 of a transaction
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 16'h00aa; bus.wdata0 = 8'h5a;
    wait_gnt(who);
    check("mr_gnt", who, 0);
    bus.req0 = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_mstart", bus.m_start, 1'b0);
    check("mr_cmd", {bus.m_r_w, bus.m_w_addr, bus.m_w_data, bus.m_r_addr}, 42'h0);
    check("mr_rdata", {bus.rdata1, bus.rdata0}, 16'h0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1 || bus.err || bus.gnt0 || bus.gnt1) bad++;
    end
    check("mr_no_done", bad, 0);
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 16'h0055; bus.wdata0 = 8'ha5;
    wait_gnt(who);
    check("mr_regnt", who, 0);
    check("mr_recmd", {bus.m_w_addr, bus.m_w_data}, {16'h0055, 8'ha5});
    bus.req0 = 1'b0;
    finish_txn(0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
